// File: rtl/muxn_pipe_reg.sv
// -----------------------------------------------------------------------------
// muxn_pipe_reg
//
// Purpose:
//   N-input, WIDTH-bit selector followed by a pipeline register. It is used as
//   an operand/forwarding select at a datapath stage boundary. It adds
//   stall (hold), flush (bubble), a registered valid bit and a sticky
//   illegal-select flag. Select codes at or above NUM_IN return DEFAULT_VAL,
//   so the select path never holds state between edges.
//
// Optional feature (macro MUX_ERR_CNT_EN):
//   defined   -> err_cnt is a saturating 8-bit count of illegal-select events.
//   undefined -> err_cnt is tied to 8'd0 and no counter flops exist.
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   in_flat    in   NUM_IN*WIDTH  input k = in_flat[k*WIDTH +: WIDTH]
//   sel        in   SEL_W         binary select
//   in_valid   in   1             upstream stage holds a valid instruction
//   stall      in   1             hold the output register
//   flush      in   1             kill the output register (bubble)
//   err_clr    in   1             clear sticky error flag / counter
//   out        out  WIDTH         registered selected data
//   out_valid  out  1             registered valid
//   sel_err    out  1             sticky illegal-select flag
//   err_cnt    out  8             illegal-select event count
//
// Valid semantics: there is no backpressure handshake. in_valid qualifies the
// data presented on in_flat/sel. It is captured into out_valid on every
// non-stalled, non-flushed edge. stall freezes out/out_valid. flush forces a
// bubble (out_valid=0) and takes priority over stall.
// -----------------------------------------------------------------------------
module muxn_pipe_reg #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 3,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter logic [WIDTH-1:0] FLUSH_VAL   = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [7:0]              err_cnt
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((2 ** SEL_W) < NUM_IN) begin : g_sel_w_check
        $error("muxn_pipe_reg: SEL_W=%0d cannot address NUM_IN=%0d inputs", SEL_W, NUM_IN);
    end
    if (NUM_IN < 2 || NUM_IN > 8) begin : g_num_in_check
        $error("muxn_pipe_reg: NUM_IN=%0d outside 2..8", NUM_IN);
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("muxn_pipe_reg: WIDTH=%0d outside 1..64", WIDTH);
    end

    // ------------------------------------------------------------------
    // Combinational select
    // ------------------------------------------------------------------
    logic [31:0]      sel_ext;
    logic [WIDTH-1:0] pick;
    logic             ill;

    // A fixed 32-bit view of sel keeps the comparisons against integer
    // constants width-clean for any SEL_W.
    assign sel_ext = 32'(sel);

    always_comb begin
        pick = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_ext == 32'(k)) begin
                pick = in_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // An illegal select only counts when it would actually be loaded. When
    // NUM_IN == 2**SEL_W the comparison is constant-false.
    assign ill = in_valid & ~stall & ~flush & (sel_ext >= 32'(NUM_IN));

    // ------------------------------------------------------------------
    // Output register: flush > stall > load
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_d,       out_q;
    logic             out_valid_d, out_valid_q;
    logic             sel_err_d,   sel_err_q;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_d       = FLUSH_VAL;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            out_d       = pick;
            out_valid_d = in_valid;
        end
    end

    // Set wins over clear so an event in the clearing cycle is not lost.
    always_comb begin
        sel_err_d = sel_err_q;
        if (ill) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= FLUSH_VAL;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

    // ------------------------------------------------------------------
    // Optional illegal-select event counter
    // ------------------------------------------------------------------
`ifdef MUX_ERR_CNT_EN
    logic [7:0] err_cnt_d, err_cnt_q;

    // Clear restarts the count. An event in the same cycle becomes the
    // first count. Otherwise increment, saturating at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = ill ? 8'd1 : 8'd0;
        end else if (ill && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_muxn_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_muxn_pipe_reg
//
// Directed plus randomised stimulus for muxn_pipe_reg (WIDTH=32, NUM_IN=3,
// SEL_W=2). Every driven cycle pushes the expected registered state
// {out, out_valid, sel_err, err_cnt} onto exp_q. The entry is popped and
// compared #1 after the edge that should produce it. The err_cnt
// expectation follows MUX_ERR_CNT_EN in the same way as the design build.
// -----------------------------------------------------------------------------
module tb_muxn_pipe_reg;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
    localparam int EXP_W  = WIDTH + 1 + 1 + 8;

`ifdef MUX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]        in_vals [NUM_IN];
    logic [NUM_IN*WIDTH-1:0] in_flat;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid, stall, flush, err_clr;
    logic [WIDTH-1:0]        out;
    logic                    out_valid, sel_err;
    logic [7:0]              err_cnt;

    assign in_flat = {in_vals[2], in_vals[1], in_vals[0]};

    muxn_pipe_reg #(
        .WIDTH      (WIDTH),
        .NUM_IN     (NUM_IN),
        .SEL_W      (SEL_W),
        .DEFAULT_VAL(32'h0000_0000),
        .FLUSH_VAL  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_flat  (in_flat),
        .sel      (sel),
        .in_valid (in_valid),
        .stall    (stall),
        .flush    (flush),
        .err_clr  (err_clr),
        .out      (out),
        .out_valid(out_valid),
        .sel_err  (sel_err),
        .err_cnt  (err_cnt)
    );

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_out;
    logic             m_valid;
    logic             m_err;
    logic [7:0]       m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out   = 32'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 8'd0;
    endtask

    // Drive one cycle, predict the post-edge state, then compare it after the edge.
    task automatic step(input string tag, input logic [1:0] s, input logic v,
                        input logic st, input logic fl, input logic clr);
        logic [WIDTH-1:0] p;
        logic             il;
        logic [EXP_W-1:0] e;
        sel = s; in_valid = v; stall = st; flush = fl; err_clr = clr;

        p  = (int'(s) < NUM_IN) ? in_vals[s] : 32'h0;
        il = v && !st && !fl && (int'(s) >= NUM_IN);
        if (fl) begin
            m_out = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_out = p; m_valid = v;
        end
        if (il)       m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (CNT_EN) begin
            if (clr)                       m_cnt = il ? 8'd1 : 8'd0;
            else if (il && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        exp_q.push_back({m_out, m_valid, m_err, m_cnt});

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".out"},       out,              e[EXP_W-1 -: WIDTH]);
        check({tag, ".out_valid"}, 32'(out_valid),   32'(e[9]));
        check({tag, ".sel_err"},   32'(sel_err),     32'(e[8]));
        check({tag, ".err_cnt"},   32'(err_cnt),     32'(e[7:0]));
    endtask

    task automatic set_inputs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        in_vals[0] = a; in_vals[1] = b; in_vals[2] = c;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        sel = '0; in_valid = 0; stall = 0; flush = 0; err_clr = 0;
        set_inputs(32'h0, 32'h0, 32'h0);
        model_reset();

        // Reset state
        #3;
        check("reset.out",       out,            32'h0);
        check("reset.out_valid", 32'(out_valid), 32'h0);
        check("reset.sel_err",   32'(sel_err),   32'h0);
        check("reset.err_cnt",   32'(err_cnt),   32'h0);
        #4 rst_n = 1'b1;   // release between edges

        // 1. Basic selection
        set_inputs(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        step("t1.sel0", 2'd0, 1, 0, 0, 0);
        step("t1.sel1", 2'd1, 1, 0, 0, 0);
        step("t1.sel2", 2'd2, 1, 0, 0, 0);
        step("t1.inv",  2'd1, 0, 0, 0, 0);

        // 2. Illegal select, sticky flag, clear
        step("t2.ill",   2'd3, 1, 0, 0, 0);
        step("t2.hold0", 2'd0, 1, 0, 0, 0);
        step("t2.hold1", 2'd2, 1, 0, 0, 0);
        step("t2.ill_novalid", 2'd3, 0, 0, 0, 0);
        step("t2.clr",   2'd0, 1, 0, 0, 1);
        step("t2.post",  2'd1, 1, 0, 0, 0);

        // 3. Stall holds while inputs and sel change
        step("t3.load", 2'd1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_inputs($urandom, $urandom, $urandom);
            step("t3.stall", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1, 0, 0);
        end
        set_inputs(32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003);
        step("t3.resume", 2'd0, 1, 0, 0, 0);
        step("t3.stall_ill", 2'd3, 1, 1, 0, 0);   // stalled: no event

        // 4. Flush beats stall
        step("t4.flush_stall", 2'd2, 1, 1, 1, 0);
        step("t4.flush_ill",   2'd3, 1, 0, 1, 0); // flushed: no event
        step("t4.reload",      2'd2, 1, 0, 0, 0);

        // Randomised mixed traffic
        for (int i = 0; i < 40; i++) begin
            set_inputs($urandom, $urandom, $urandom);
            step("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        // 5. Counter saturation, then clear coincident with an event
        step("t5.clr", 2'd0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            step("t5.sat", 2'd3, 1, 0, 0, 0);
        end
        step("t5.clr_ill", 2'd3, 1, 0, 0, 1);

        // 6. Asynchronous reset mid-cycle while out holds 0x33333333
        set_inputs(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        step("t6.load", 2'd2, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6.async.out",       out,            32'h0);
        check("t6.async.out_valid", 32'(out_valid), 32'h0);
        check("t6.async.sel_err",   32'(sel_err),   32'h0);
        check("t6.async.err_cnt",   32'(err_cnt),   32'h0);
        #3 rst_n = 1'b1;
        step("t6.first", 2'd0, 1, 0, 0, 0);
        step("t6.second", 2'd1, 1, 0, 0, 0);

        check("final.queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muxn_pipe_reg.md
Name: muxn_pipe_reg

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output stage, for use as a pipeline-boundary operand/forwarding select in the MIPS datapath.
- Generalises the fixed 2:1 and 3:1 combinational muxes:
  - configurable width and input count;
  - defined output for unused select codes, where the older muxes would latch;
  - stall (hold), flush, a valid bit and sticky illegal-select detection.

Parameters:
- WIDTH, 32: data width per input, 1..64.
- NUM_IN, 3: number of inputs, 2..8.
- SEL_W, 2: select width; must satisfy 2^SEL_W >= NUM_IN (elaboration check, $error otherwise).
- DEFAULT_VAL, 0: value selected when sel >= NUM_IN.
- FLUSH_VAL, 0: output value after reset or flush.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_flat  input  NUM_IN*WIDTH  concatenated inputs; input k = in_flat[k*WIDTH +: WIDTH].
- sel  input  SEL_W  binary select.
- in_valid  input  1  upstream stage holds a valid instruction.
- stall  input  1  hold the output register.
- flush  input  1  kill the output register (bubble).
- err_clr  input  1  clear the sticky error flag.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- sel_err  output  1  sticky illegal-select flag.
- err_cnt  output  8  illegal-select event count (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out = FLUSH_VAL, out_valid = 0, sel_err = 0, err_cnt = 0.
  - Takes effect immediately, mid-operation included.
  - Release is synchronous to the next clk edge.
- pick (combinational): input[sel] if sel < NUM_IN, else DEFAULT_VAL. Fully specified; no latch inferred for any sel value.
- Register update at each rising edge, with priority flush > stall > load:
  - flush=1: out <= FLUSH_VAL, out_valid <= 0. Applies even when stall=1.
  - else stall=1: out and out_valid hold their values.
  - else: out <= pick, out_valid <= in_valid.
- Latency: exactly 1 cycle from in_flat/sel to out when stall=0 and flush=0.
- Illegal-select event ("ill") = in_valid & ~stall & ~flush & (sel >= NUM_IN).
  - Events are not counted when in_valid=0.
- sel_err:
  - Set on ill, cleared on err_clr.
  - Simultaneous ill and err_clr: set wins (sel_err = 1).
  - When NUM_IN = 2^SEL_W, ill can never occur and sel_err stays 0.
- out changes only at clock edges or on reset. Inputs have no effect between edges.

Optional Feature:
- Macro: MUX_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 on each ill event and saturates at 255.
  - err_clr zeroes it.
  - ill and err_clr in the same cycle: err_cnt = 1.
- Undefined: err_cnt is tied to 8'd0 and no counter flops are instantiated. sel_err behaves the same in both builds.

Test Plan (WIDTH=32, NUM_IN=3, SEL_W=2):
1. Inputs 0x11111111 / 0x22222222 / 0x33333333; sel = 0,1,2 on consecutive cycles with in_valid=1 -> out = 0x11111111, 0x22222222, 0x33333333 one cycle later each, with out_valid=1.
2. sel=3, in_valid=1 -> out=0x00000000 next cycle, sel_err=1. It stays 1 after sel returns to 0 until err_clr; err_cnt=1 with macro, 0 without.
3. Load 0x22222222, then stall=1 for 3 cycles while sel and inputs change -> out holds 0x22222222 and out_valid holds 1. Next cycle after stall drops, out = new pick.
4. stall=1 and flush=1 together -> out=0x00000000, out_valid=0 next cycle.
5. Macro on: 300 consecutive ill cycles -> err_cnt=255 (saturates). Then err_clr with ill in the same cycle -> err_cnt=1, sel_err=1.
6. rst_n pulsed low mid-stream, asynchronous to clk, while out=0x33333333 -> out=0, out_valid=0, sel_err=0 immediately. First load occurs on the first edge after release.
